// File: rtl/adc_mean_tracker.sv
// Block-average tracker for raw ADC samples; the held mean feeds the frequency estimator's threshold.
// Optional min/max trackers are built when ADC_MEAN_TRACKER_MINMAX_EN is defined.
module adc_mean_tracker #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned MEAN_W      = 14,
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter int unsigned MEAN_INIT   = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic [MEAN_W-1:0] mean,
    output logic              mean_stb,
    output logic              mean_valid,
    output logic [DATA_W-1:0] data_min,
    output logic [DATA_W-1:0] data_max
);

    localparam int unsigned ACC_W = DATA_W + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = {WINDOW_LOG2{1'b1}};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [MEAN_W-1:0]      mean_q, mean_d;
    logic                   mean_stb_q, mean_stb_d;
    logic [ACC_W-1:0]       sum_s;
    logic [ACC_W-1:0]       avg_s;
    logic                   last_s;

    // The accumulator cannot overflow: a full window of all-max samples fits ACC_W exactly.
    assign sum_s  = acc_q + ACC_W'(data);
    assign avg_s  = sum_s >> WINDOW_LOG2;
    assign last_s = (cnt_q == CNT_LAST);

    // Next-state logic for the accumulator, counter, FSM and mean output.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mean_d     = mean_q;
        mean_stb_d = 1'b0;
        if (clear) begin
            acc_d = {ACC_W{1'b0}};
            cnt_d = {WINDOW_LOG2{1'b0}};
        end else if (sample_en) begin
            if (last_s) begin
                mean_d     = MEAN_W'(avg_s[DATA_W-1:0]);
                mean_stb_d = 1'b1;
                acc_d      = {ACC_W{1'b0}};
                cnt_d      = {WINDOW_LOG2{1'b0}};
                case (state_q)
                    ST_FILL: state_d = ST_RUN;
                    ST_RUN:  state_d = ST_RUN;
                    default: state_d = ST_RUN;
                endcase
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + WINDOW_LOG2'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            acc_q      <= {ACC_W{1'b0}};
            cnt_q      <= {WINDOW_LOG2{1'b0}};
            mean_q     <= MEAN_W'(MEAN_INIT);
            mean_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mean_q     <= mean_d;
            mean_stb_q <= mean_stb_d;
        end
    end

    assign mean       = mean_q;
    assign mean_stb   = mean_stb_q;
    assign mean_valid = (state_q == ST_RUN);

`ifdef ADC_MEAN_TRACKER_MINMAX_EN
    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] smp_min_s, smp_max_s;

    assign smp_min_s = (data < run_min_q) ? data : run_min_q;
    assign smp_max_s = (data > run_max_q) ? data : run_max_q;

    // Running extremes fold in the current sample; completion latches them and restarts.
    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        if (clear) begin
            run_min_d = {DATA_W{1'b1}};
            run_max_d = {DATA_W{1'b0}};
        end else if (sample_en) begin
            if (last_s) begin
                min_d     = smp_min_s;
                max_d     = smp_max_s;
                run_min_d = {DATA_W{1'b1}};
                run_max_d = {DATA_W{1'b0}};
            end else begin
                run_min_d = smp_min_s;
                run_max_d = smp_max_s;
            end
        end else begin
            run_min_d = run_min_q;
        end
    end

    // Tracker registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_q <= {DATA_W{1'b1}};
            run_max_q <= {DATA_W{1'b0}};
            min_q     <= {DATA_W{1'b0}};
            max_q     <= {DATA_W{1'b0}};
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign data_min = min_q;
    assign data_max = max_q;
`else
    assign data_min = {DATA_W{1'b0}};
    assign data_max = {DATA_W{1'b0}};
`endif

endmodule
